// File: rtl/disco_mem_arbiter.sv
// Arbiter sharing the DISCO program/data memory between instruction fetch (IF)
// and load/store (LS); one transaction in flight, LS priority with an IF fairness guard.
module disco_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int LS_BURST_MAX = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int BCW = $clog2(LS_BURST_MAX + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic          ls;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    state_t         state_q, state_d;
    txn_t           txn_q, txn_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [BCW-1:0] burst_q, burst_d;

    logic           pick_ls, pick_if;
    logic [AW-1:0]  req_addr;

    // LS wins a tie unless IF has already been passed over LS_BURST_MAX times
    assign pick_ls  = ls_req && (!if_req || burst_q != BCW'(LS_BURST_MAX));
    assign pick_if  = if_req && !pick_ls;
    assign req_addr = pick_ls ? ls_addr : if_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            txn_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        burst_d = burst_q;
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_ls || pick_if) begin
                    ls_gnt      = pick_ls;
                    if_gnt      = pick_if;
                    txn_d.ls    = pick_ls;
                    txn_d.we    = pick_ls && ls_we;
                    txn_d.addr  = {req_addr[AW-1:1], 1'b0};
                    txn_d.wdata = pick_ls ? ls_wdata : '0;
                    wcnt_d      = '0;
                    rdata_d     = '0;
                    if (pick_ls && if_req) begin
                        if (burst_q != BCW'(LS_BURST_MAX))
                            burst_d = burst_q + BCW'(1);
                    end else begin
                        burst_d = '0;
                    end
                    // Misaligned accesses skip the memory and complete with an error
                    if (req_addr[0]) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    rdata_d = txn_q.we ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_req && txn_q.we;
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;

    assign if_rvalid = (state_q == RESP) && !txn_q.ls;
    assign ls_rvalid = (state_q == RESP) && txn_q.ls;
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign ls_rdata  = ls_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid && err_q;
    assign ls_err    = ls_rvalid && err_q;

endmodule

// File: tb/tb_disco_mem_arbiter.sv
// Directed bench for disco_mem_arbiter: table of single transactions against a
// wait-state memory model, plus reset, fairness and stray-ack sequences.
module tb_disco_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [15:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [15:0] ls_addr = '0, ls_wdata = '0;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [15:0] ls_rdata;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    int   mem_wait  = 0;
    int   mem_cyc   = 0;
    logic ack_force = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    disco_mem_arbiter #(.AW(16), .DW(16), .LS_BURST_MAX(4), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory model: acks after mem_wait wait states; negative mem_wait never acks
    assign mem_ack = ack_force || (mem_req && mem_wait >= 0 && mem_cyc == mem_wait);

    always @(posedge clock) begin
        if (!reset) mem_cyc <= 0;
        else        mem_cyc <= (mem_req && !mem_ack) ? mem_cyc + 1 : 0;
    end

    typedef struct {
        logic        ls;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mrd;
        int          wait_n;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          exp_mreq;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata,
                ls_err, mem_req, mem_we, mem_addr, mem_wdata, busy};
    endfunction

    task automatic run(input int idx);
        vec_t v = vecs[idx];
        int gcyc = -1, rcyc = -1, mreq = 0, mbad = 0, other = 0;
        logic [15:0] rd = '0;
        logic er = 1'b0;
        mem_wait  = v.wait_n;
        mem_rdata = v.mrd;
        if (v.ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int cyc = 0; cyc < 40 && rcyc < 0; cyc++) begin
            #4;
            if ((v.ls ? ls_gnt : if_gnt) && gcyc < 0) gcyc = cyc;
            if (mem_req) begin
                mreq++;
                if (mem_we !== v.we || mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata))
                    mbad++;
            end
            if (v.ls ? if_rvalid : ls_rvalid) other++;
            if (v.ls ? ls_rvalid : if_rvalid) begin
                rcyc = cyc;
                rd   = v.ls ? ls_rdata : if_rdata;
                er   = v.ls ? ls_err : if_err;
            end
            next_cyc();
            if (gcyc >= 0) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        chk($sformatf("vec%0d gnt_cycle", idx), 64'(gcyc), 64'(0));
        chk($sformatf("vec%0d mem_req_cycles", idx), 64'(mreq), 64'(v.exp_mreq));
        chk($sformatf("vec%0d mem_bus_errors", idx), 64'(mbad), 64'(0));
        chk($sformatf("vec%0d other_rvalid", idx), 64'(other), 64'(0));
        chk($sformatf("vec%0d rvalid_cycle", idx), 64'(rcyc), 64'(v.exp_lat));
        chk($sformatf("vec%0d rdata", idx), 64'(rd), 64'(v.exp_rd));
        chk($sformatf("vec%0d err", idx), 64'(er), 64'(v.exp_err));
    endtask

    initial begin
        logic exp_seq[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   ng;
        int   gseen;

        //          ls    we    addr      wdata     mrd       wait lat-exp rd  err  mreq lat
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 0,  16'hA5C3, 1'b0, 1,  2};
        vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hFFFF, 3,  16'h0000, 1'b0, 4,  5};
        vecs[2] = '{1'b1, 1'b0, 16'h0402, 16'h0000, 16'h5A5A, 1,  16'h5A5A, 1'b0, 2,  3};
        vecs[3] = '{1'b1, 1'b0, 16'h0101, 16'h0000, 16'h7777, 0,  16'h0000, 1'b1, 0,  1};
        vecs[4] = '{1'b0, 1'b0, 16'h0033, 16'h0000, 16'h7777, 0,  16'h0000, 1'b1, 0,  1};
        vecs[5] = '{1'b1, 1'b0, 16'h0600, 16'h0000, 16'hBEEF, -1, 16'h0000, 1'b1, 15, 16};

        // Reset state
        next_cyc();
        #4;
        chk("reset_outputs", all_outs(), 64'(0));
        next_cyc();
        reset = 1'b1;

        // Reset asserted mid-BUSY with memory stalled
        mem_wait = -1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0300;
        #4;
        chk("pre_reset_gnt", 64'(ls_gnt), 64'(1));
        next_cyc();
        ls_req = 1'b0;
        next_cyc();
        #4;
        chk("pre_reset_busy", 64'({mem_req, busy}), 64'(2'b11));
        next_cyc();
        reset = 1'b0;
        #4;
        chk("mid_busy_reset_outputs", all_outs(), 64'(0));
        gseen = 0;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            #4;
            if (ls_rvalid || if_rvalid || mem_req) gseen++;
        end
        chk("reset_no_rvalid", 64'(gseen), 64'(0));
        next_cyc();
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run(i);

        // Fairness: both requesters held continuously
        mem_wait = 0;
        if_req = 1'b1; if_addr = 16'h0020;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100;
        ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
            #4;
            if (if_gnt || ls_gnt) begin
                chk($sformatf("fair_grant%0d_is_ls", ng), 64'(ls_gnt), 64'(exp_seq[ng]));
                ng++;
            end
            next_cyc();
        end
        chk("fair_grant_count", 64'(ng), 64'(10));
        if_req = 1'b0;
        ls_req = 1'b0;
        for (int i = 0; i < 10 && busy; i++) next_cyc();

        // Timeout, then a stray ack in IDLE
        run(5);
        ack_force = 1'b1;
        #4;
        chk("stray_ack_idle", 64'({busy, mem_req, if_rvalid, ls_rvalid}), 64'(0));
        next_cyc();
        ack_force = 1'b0;
        #4;
        chk("stray_ack_after", 64'({busy, mem_req, if_rvalid, ls_rvalid, ls_err}), 64'(0));
        next_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disco_mem_arbiter.md
# disco_mem_arbiter

- Shares the single DISCO program/data memory between the core's instruction-fetch port (IF) and its load/store port (LS).
- Sits between the core and the memory and serialises every access: one transaction in flight at a time.
- Arbitration gives LS priority with an IF fairness guard.
- Includes a memory-acknowledge timeout and misaligned-address rejection.

## Interface

Parameters:
- AW, 16, byte-address width
- DW, 16, data word width
- LS_BURST_MAX, 4, consecutive LS grants allowed while IF is waiting before IF is forced (≥1)
- TIMEOUT, 15, BUSY cycles without mem_ack before the transaction is aborted (≥1)

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  IF request; held with if_addr until if_gnt
- if_addr  in  AW  IF byte address
- if_gnt  out  1  one-cycle grant to IF
- if_rvalid  out  1  one-cycle IF completion
- if_rdata  out  DW  IF read data, valid with if_rvalid
- if_err  out  1  IF error, valid with if_rvalid
- ls_req  in  1  LS request; held with ls_we, ls_addr and ls_wdata until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  LS byte address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  one-cycle grant to LS
- ls_rvalid  out  1  one-cycle LS completion (loads and stores)
- ls_rdata  out  DW  load data; 0 for stores
- ls_err  out  1  LS error, valid with ls_rvalid
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  AW  byte address (always even)
- mem_wdata  out  DW  write data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE

## Operation

FSM states: IDLE, BUSY, RESP.

IDLE
- Evaluates requests combinationally.
- Grant selection:
  - only one requester active: that requester wins;
  - both active: LS wins, unless burst_cnt == LS_BURST_MAX, in which case IF wins.
- The winner's gnt is high in this cycle only.
- Owner, we, addr and wdata are latched at the clock edge.
- IF requests always latch we = 0.
- Even address: next state is BUSY.
- Odd address (addr[0]=1): next state is RESP with err = 1; no memory access is made.

burst_cnt (width $clog2(LS_BURST_MAX+1), saturating)
- Incremented on an LS grant while if_req = 1.
- Cleared on any IF grant, and on an LS grant while if_req = 0.

BUSY
- mem_req = 1; mem_we, mem_addr and mem_wdata are driven from the latched values.
- A wait counter starts at 0 on entry and increments each BUSY cycle.
- mem_ack = 1: capture mem_rdata (forced to 0 for stores), set err = 0, go to RESP.
- Counter reaches TIMEOUT-1 with no ack: drop mem_req, set rdata = 0 and err = 1, go to RESP.

RESP
- The owner's rvalid is high for one cycle, with rdata and err; then IDLE.
- The non-owner's outputs stay 0.
- No grant is issued in RESP.

Other rules:
- mem_ack outside BUSY is ignored.
- A request dropped before its gnt is legal and has no effect.
- Reset (asynchronous, any state): go to IDLE and clear burst_cnt, the wait counter and the latched transaction; an in-flight access is abandoned with no rvalid.

## Timing

- Reset values: all outputs are 0; mem_addr and mem_wdata are 0.
- Latency with a zero-wait memory:
  - gnt in cycle N;
  - mem_req in cycle N+1, with mem_ack in the same cycle;
  - rvalid in cycle N+2.
- Each memory wait state adds one cycle.
- Misaligned access: gnt in N, rvalid with err in N+1.
- Timeout: mem_req is high for exactly TIMEOUT cycles (N+1 to N+TIMEOUT); rvalid with err in N+TIMEOUT+1.
- Back-to-back: the next gnt is at the earliest in the cycle after RESP, so with a zero-wait memory there is one transaction every 3 cycles.
- mem_* outputs are registered and stable throughout BUSY.

## Test plan

- Reset and idle: hold reset low mid-BUSY with mem_ack = 0, then release. Required: all outputs 0, no rvalid, and the first request afterwards is granted normally.
- IF read, zero-wait: if_addr = 0x0010, mem_ack tied high, mem_rdata = 0xA5C3. Required: if_gnt in cycle N; mem_req with mem_addr = 0x0010 in N+1; if_rvalid with if_rdata = 0xA5C3 and if_err = 0 in N+2.
- LS store with 3 wait states: ls_we = 1, ls_addr = 0x0200, ls_wdata = 0x1234. Required: mem_req high for 4 cycles with mem_we = 1 and mem_wdata = 0x1234; then ls_rvalid = 1, ls_rdata = 0, ls_err = 0.
- Fairness: LS_BURST_MAX = 4, if_req and ls_req held high continuously. Required grant sequence LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
- Timeout: TIMEOUT = 15, mem_ack held at 0. Required: mem_req high for exactly 15 cycles, then rvalid with err = 1 and rdata = 0. A mem_ack in the following IDLE cycle has no effect.
- Misaligned: ls_addr = 0x0101. Required: ls_gnt, then ls_rvalid with ls_err = 1 in the next cycle; mem_req never asserted.
